// File: rtl/spi_regs_pkg.sv
// Register map and frame layout shared by the SPI write-only control port.
// The port feeds the PWM stage's enable and duty-cycle registers.
package spi_regs_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_W     = 7;
  localparam int REG_W      = 8;
  localparam int CNT_W      = 5;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  // A count of exactly FRAME_BITS is a complete frame.
  // CNT_SAT is the sticky "overlong" marker.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } frame_t;

  function automatic logic frame_writable(input frame_t f, input logic [ADDR_W-1:0] max_addr);
    return f.rw && (f.addr <= max_addr);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous pin.
// The reset value is chosen per pin so that reset release never looks like an edge.
module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int unsigned D = (DEPTH < 2) ? 2 : DEPTH;

  logic [D-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chain <= {D{RST_VAL}};
    else        r_chain <= {r_chain[D-2:0], i_d};
  end

  assign o_q = r_chain[D-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target: 16-bit frames {rw, addr[6:0], data[7:0]} load
// five 8-bit control registers for the PWM block. A write commits on nCS rising.
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             copi,
  input  logic             ncs,
  output logic [REG_W-1:0] en_reg_out_7_0,
  output logic [REG_W-1:0] en_reg_out_15_8,
  output logic [REG_W-1:0] en_reg_pwm_7_0,
  output logic [REG_W-1:0] en_reg_pwm_15_8,
  output logic [REG_W-1:0] pwm_duty_cycle,
  output logic             wr_strobe
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction

  logic w_sclk_s;
  logic w_copi_s;
  logic w_ncs_s;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sclk),
    .o_q   (w_sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (copi),
    .o_q   (w_copi_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ncs),
    .o_q   (w_ncs_s)
  );

  // ---- stage p1: edge detection on the synchronized pins ----
  logic r_sclk_p1;
  logic r_ncs_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_p1 <= 1'b0;
      r_ncs_p1  <= 1'b1;
    end else begin
      r_sclk_p1 <= w_sclk_s;
      r_ncs_p1  <= w_ncs_s;
    end
  end

  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_p1;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_p1;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_p1;

  // ---- stage p2: frame assembly ----
  logic [FRAME_BITS-1:0] r_shift_p2;
  logic [CNT_W-1:0]      r_count_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_p2 <= '0;
      r_count_p2 <= '0;
    end else if (w_ncs_fall) begin
      r_shift_p2 <= '0;
      r_count_p2 <= '0;
    end else if (!w_ncs_s && w_sclk_rise) begin
      r_shift_p2 <= {r_shift_p2[FRAME_BITS-2:0], w_copi_s};
      r_count_p2 <= sat_inc(r_count_p2);
    end
  end

  frame_t w_frame;
  logic   w_commit;

  assign w_frame  = frame_t'(r_shift_p2);
  assign w_commit = w_ncs_rise && (r_count_p2 == CNT_FULL) && frame_writable(w_frame, MAX_ADDR);

  // ---- stage p3: register file and write strobe ----
  logic [REG_W-1:0] r_en_out_lo;
  logic [REG_W-1:0] r_en_out_hi;
  logic [REG_W-1:0] r_en_pwm_lo;
  logic [REG_W-1:0] r_en_pwm_hi;
  logic [REG_W-1:0] r_duty;
  logic             r_wr_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
      r_wr_strobe <= 1'b0;
    end else begin
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        case (w_frame.addr)
          ADDR_EN_OUT_7_0:  r_en_out_lo <= w_frame.data;
          ADDR_EN_OUT_15_8: r_en_out_hi <= w_frame.data;
          ADDR_EN_PWM_7_0:  r_en_pwm_lo <= w_frame.data;
          ADDR_EN_PWM_15_8: r_en_pwm_hi <= w_frame.data;
          ADDR_PWM_DUTY:    r_duty      <= w_frame.data;
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign wr_strobe       = r_wr_strobe;

endmodule
